// File: rtl/led_sense_if.sv
// Bundles the control, analog-facing and result-handshake signals of the LED sense sequencer.
//   master : sequencer side (drives led_en, latch_clr, busy, result, overflow, result_valid)
//   slave  : controller/consumer side (drives start, abort, cmp_in, result_ready)
interface led_sense_if #(
    parameter int unsigned CNT_W = 5
);
    logic             start;
    logic             abort;
    logic             cmp_in;
    logic             led_en;
    logic             latch_clr;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             overflow;
    logic             result_valid;
    logic             result_ready;

    modport master (
        input  start, abort, cmp_in, result_ready,
        output led_en, latch_clr, busy, result, overflow, result_valid
    );

    modport slave (
        output start, abort, cmp_in, result_ready,
        input  led_en, latch_clr, busy, result, overflow, result_valid
    );
endinterface

// File: rtl/led_sense_sequencer.sv
// LED drive / sense sequencer. One measurement: drive led_en for PULSE_CYCLES (clearing the
// sense latch in the first cycle), wait SETTLE_CYCLES, then count synchronized comparator highs
// over WINDOW_CYCLES. The saturating count and a sticky overflow flag are offered on a
// valid/ready handshake.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : led_sense_if.master (start, abort, cmp_in, result_ready in;
//          led_en, latch_clr, busy, result, overflow, result_valid out, all registered)
module led_sense_sequencer #(
    parameter int unsigned PULSE_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned WINDOW_CYCLES = 16,
    parameter int unsigned CNT_W         = 5
) (
    input  logic           clk,
    input  logic           rst,
    led_sense_if.master    bus
);
    localparam int unsigned MaxPs     = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES
                                                                       : SETTLE_CYCLES;
    localparam int unsigned MaxCycles = (MaxPs > WINDOW_CYCLES) ? MaxPs : WINDOW_CYCLES;
    localparam int unsigned TimerW    = $clog2(MaxCycles) + 1;

    typedef enum logic [1:0] {StIdle, StPulse, StSettle, StSample} state_e;

    state_e             state_q, state_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               valid_q, valid_d;
    logic               led_en_q, led_en_d;
    logic               latch_clr_q, latch_clr_d;
    logic               busy_q, busy_d;
    logic               cmp_meta_q, cmp_s_q;
    logic               accept, done, entering;

    // A new measurement may only start once any pending result is (or is being) consumed.
    assign accept   = bus.start && !bus.abort && (!valid_q || bus.result_ready);
    assign done     = (state_q == StSample) && (timer_q == '0) && !bus.abort;
    assign entering = (state_q == StIdle) && (state_d == StPulse);

    // State register plus all registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            valid_q     <= 1'b0;
            led_en_q    <= 1'b0;
            latch_clr_q <= 1'b0;
            busy_q      <= 1'b0;
            cmp_meta_q  <= 1'b0;
            cmp_s_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            valid_q     <= valid_d;
            led_en_q    <= led_en_d;
            latch_clr_q <= latch_clr_d;
            busy_q      <= busy_d;
            cmp_meta_q  <= bus.cmp_in;
            cmp_s_q     <= cmp_meta_q;
        end
    end

    // Next state; the timer is loaded with (phase length - 1) and counts down to zero.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StPulse;
                    timer_d = TimerW'(PULSE_CYCLES - 1);
                end
            end
            StPulse: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (timer_q == '0) begin
                    state_d = StSettle;
                    timer_d = TimerW'(SETTLE_CYCLES - 1);
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StSettle: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (timer_q == '0) begin
                    state_d = StSample;
                    timer_d = TimerW'(WINDOW_CYCLES - 1);
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StSample: begin
                if (bus.abort || (timer_q == '0)) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and the accumulator.
    always_comb begin
        led_en_d    = (state_d == StPulse);
        latch_clr_d = entering;
        busy_d      = (state_d != StIdle);

        acc_d = acc_q;
        ovf_d = ovf_q;
        if (entering) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if ((state_q == StSample) && cmp_s_q) begin
            if (acc_q == {CNT_W{1'b1}}) begin
                ovf_d = 1'b1;
            end else begin
                acc_d = acc_q + CNT_W'(1);
            end
        end

        result_d   = result_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;
        if (valid_q && bus.result_ready) begin
            valid_d = 1'b0;
        end
        // Load includes the final window sample, so take the updated accumulator.
        if (done) begin
            result_d   = acc_d;
            overflow_d = ovf_d;
            valid_d    = 1'b1;
        end
    end

    assign bus.led_en       = led_en_q;
    assign bus.latch_clr    = latch_clr_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.overflow     = overflow_q;
    assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_led_sense_sequencer.sv
// Bench for led_sense_sequencer: two instances (CNT_W=5 and CNT_W=4) share one stimulus stream.
// A timeline model (edges since acceptance, unbounded sample count) predicts every output each
// cycle; directed steps add literal expectations at the key edges.
module tb_led_sense_sequencer;
    localparam int unsigned P = 4;
    localparam int unsigned S = 3;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst, start, abort, cmp_in, result_ready;
    bit   tog_cmp = 1'b0;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    led_sense_if #(.CNT_W(5)) bus_a ();
    led_sense_if #(.CNT_W(4)) bus_b ();

    assign bus_a.start = start;
    assign bus_a.abort = abort;
    assign bus_a.cmp_in = cmp_in;
    assign bus_a.result_ready = result_ready;
    assign bus_b.start = start;
    assign bus_b.abort = abort;
    assign bus_b.cmp_in = cmp_in;
    assign bus_b.result_ready = result_ready;

    led_sense_sequencer #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(5))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    led_sense_sequencer #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(4))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a measurement is a timeline of P+S+W cycles counted from the accept edge.
    bit       m_act, m_valid;
    int       m_t, m_cnt, m_final;
    bit [1:0] m_sync;

    always @(posedge clk) begin
        bit s_now, acc_ok;
        s_now = m_sync[1];
        if (rst) begin
            m_act = 0; m_valid = 0; m_final = 0; m_sync = 0; m_t = 0; m_cnt = 0;
        end else begin
            acc_ok = !m_act && start && !abort && (!m_valid || result_ready);
            if (m_valid && result_ready) m_valid = 0;
            if (m_act) begin
                if (abort) begin
                    m_act = 0;
                end else begin
                    if (m_t >= int'(P + S)) m_cnt += int'(s_now);
                    if (m_t == int'(P + S + W - 1)) begin
                        m_act = 0; m_final = m_cnt; m_valid = 1;
                    end else begin
                        m_t++;
                    end
                end
            end else if (acc_ok) begin
                m_act = 1; m_t = 0; m_cnt = 0;
            end
            m_sync = {m_sync[0], cmp_in};
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("a.led_en", 32'(bus_a.led_en), 32'(m_act && m_t < int'(P)));
            check("a.latch_clr", 32'(bus_a.latch_clr), 32'(m_act && m_t == 0));
            check("a.busy", 32'(bus_a.busy), 32'(m_act));
            check("a.result_valid", 32'(bus_a.result_valid), 32'(m_valid));
            check("a.result", 32'(bus_a.result), 32'(sat(m_final, 31)));
            check("a.overflow", 32'(bus_a.overflow), 32'(m_final > 31));
            check("b.led_en", 32'(bus_b.led_en), 32'(m_act && m_t < int'(P)));
            check("b.busy", 32'(bus_b.busy), 32'(m_act));
            check("b.result_valid", 32'(bus_b.result_valid), 32'(m_valid));
            check("b.result", 32'(bus_b.result), 32'(sat(m_final, 15)));
            check("b.overflow", 32'(bus_b.overflow), 32'(m_final > 15));
        end
    end

    // Advance n falling edges (i.e. observe after the next n rising edges).
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (tog_cmp) cmp_in = ~cmp_in;
        end
    endtask

    // Raise start for one edge; returns just after that accept edge (edge 1).
    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; cmp_in = 1'b1; result_ready = 1'b0;
        step(2);
        chk_en = 1'b1;
        check("rst.led_en", 32'(bus_a.led_en), 0);
        check("rst.busy", 32'(bus_a.busy), 0);
        check("rst.valid", 32'(bus_a.result_valid), 0);
        check("rst.result", 32'(bus_a.result), 0);
        rst = 1'b0;
        step(2);

        // 1 & 3: cmp_in steady high.
        pulse_start();
        check("t1.led_e1", 32'(bus_a.led_en), 1);
        check("t1.clr_e1", 32'(bus_a.latch_clr), 1);
        step(1);
        check("t1.clr_e2", 32'(bus_a.latch_clr), 0);
        step(2);
        check("t1.led_e4", 32'(bus_a.led_en), 1);
        step(1);
        check("t1.led_e5", 32'(bus_a.led_en), 0);
        check("t1.busy_e5", 32'(bus_a.busy), 1);
        step(18);
        check("t1.valid_e23", 32'(bus_a.result_valid), 0);
        step(1);
        check("t1.valid_e24", 32'(bus_a.result_valid), 1);
        check("t1.result", 32'(bus_a.result), 16);
        check("t1.ovf", 32'(bus_a.overflow), 0);
        check("t3.result", 32'(bus_b.result), 15);
        check("t3.ovf", 32'(bus_b.overflow), 1);
        result_ready = 1'b1;
        step(1);
        check("t1.consumed", 32'(bus_a.result_valid), 0);
        result_ready = 1'b0;

        // abort+start in IDLE stays idle.
        start = 1'b1; abort = 1'b1;
        step(1);
        check("idle_abort.busy", 32'(bus_a.busy), 0);
        start = 1'b0; abort = 1'b0;

        // 2: cmp_in steady low.
        cmp_in = 1'b0;
        step(3);
        pulse_start();
        step(22);
        check("t2.busy_e23", 32'(bus_a.busy), 1);
        step(1);
        check("t2.busy_e24", 32'(bus_a.busy), 0);
        check("t2.valid", 32'(bus_a.result_valid), 1);
        check("t2.result", 32'(bus_a.result), 0);
        check("t2.ovf", 32'(bus_a.overflow), 0);

        // 4: abort in 2nd SETTLE cycle (after edge 6), accepted with ready consuming t2.
        result_ready = 1'b1;
        pulse_start();
        result_ready = 1'b0;
        step(5);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t4.busy", 32'(bus_a.busy), 0);
        check("t4.led", 32'(bus_a.led_en), 0);
        check("t4.valid", 32'(bus_a.result_valid), 0);
        // Restart with cmp_in toggling every cycle: 8 of 16 samples high.
        tog_cmp = 1'b1;
        pulse_start();
        step(23);
        tog_cmp = 1'b0;
        check("t4.valid", 32'(bus_a.result_valid), 1);
        check("t4.result", 32'(bus_a.result), 8);
        check("t4.result_b", 32'(bus_b.result), 8);

        // 5: pending result blocks start.
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t5.busy_blocked", 32'(bus_a.busy), 0);
            check("t5.result_stable", 32'(bus_a.result), 8);
        end
        cmp_in = 1'b1;
        result_ready = 1'b1;
        step(1);
        start = 1'b0; result_ready = 1'b0;
        check("t5.valid_drop", 32'(bus_a.result_valid), 0);
        check("t5.led_rise", 32'(bus_a.led_en), 1);

        // 6: reset in 5th SAMPLE cycle (after edge 12 of this measurement).
        step(11);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6.busy", 32'(bus_a.busy), 0);
        check("t6.led", 32'(bus_a.led_en), 0);
        check("t6.valid", 32'(bus_a.result_valid), 0);
        check("t6.result", 32'(bus_a.result), 0);
        step(2);
        pulse_start();
        step(23);
        check("t6.valid_after", 32'(bus_a.result_valid), 1);
        check("t6.result_after", 32'(bus_a.result), 16);
        step(2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
